// File: rtl/hps_link_initiator_pkg.sv
// -----------------------------------------------------------------------------
// hps_link_initiator_pkg
//   Shared definitions for the initiator end of the 32-bit PIO byte-handshake
//   link: link word bit positions, FSM state encoding and the one-hot codes
//   reported on debug_state.
// -----------------------------------------------------------------------------
package hps_link_initiator_pkg;

   // Link word layout (link_out driven by the initiator, link_in by the partner)
   localparam int unsigned LINK_READY_BIT = 31;
   localparam int unsigned LINK_START_BIT = 30;
   localparam int unsigned LINK_ACK_BIT   = 31;
   localparam int unsigned LINK_DATA_MSB  = 7;
   localparam int unsigned LINK_DATA_LSB  = 0;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_START,
      ST_TX_SETUP,
      ST_TX_REQ,
      ST_TX_REL,
      ST_SETTLE,
      ST_RX_SAMPLE,
      ST_RX_REQ,
      ST_RX_REL,
      ST_DONE,
      ST_ERROR
   } state_e;

   // One-hot phase codes for debug_state
   localparam logic [3:0] DBG_IDLE = 4'b0001;
   localparam logic [3:0] DBG_TX   = 4'b0010;
   localparam logic [3:0] DBG_RX   = 4'b0100;
   localparam logic [3:0] DBG_END  = 4'b1000;

   // SETTLE belongs to the result phase: it always precedes an RX sample.
   function automatic logic [3:0] debug_code(input state_e s);
      case (s)
         ST_IDLE:                                     return DBG_IDLE;
         ST_START, ST_TX_SETUP, ST_TX_REQ, ST_TX_REL: return DBG_TX;
         ST_SETTLE, ST_RX_SAMPLE, ST_RX_REQ,
         ST_RX_REL:                                   return DBG_RX;
         default:                                     return DBG_END;
      endcase
   endfunction

endpackage

// File: rtl/hps_link_initiator_link_sync.sv
// -----------------------------------------------------------------------------
// link_sync
//   Two-flop level synchronizer for one asynchronous control bit.
//   Ports:
//     clk_i    : destination clock
//     reset_ni : synchronous active-low reset (clears both stages)
//     d_i      : asynchronous level input
//     q_o      : synchronized level output (2 cycles latency)
// -----------------------------------------------------------------------------
module link_sync (
   input  logic clk_i,
   input  logic reset_ni,
   input  logic d_i,
   output logic q_o
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge clk_i) begin
      if (!reset_ni) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/hps_link_initiator.sv
// -----------------------------------------------------------------------------
// hps_link_initiator
//   Initiator end of the 32-bit PIO byte-handshake link. A transaction sends
//   N_TX operand bytes (after a start pulse), one ready/ack handshake per byte,
//   then reads back N_RX result bytes, one handshake per byte.
//   Ports:
//     clk, reset        : clock, synchronous active-low reset
//     cmd_start         : 1-cycle pulse starting a transaction (ignored while busy)
//     tx_data/valid/ready : operand byte stream in (accepted on valid && ready)
//     rx_data/rx_valid  : result byte out, rx_valid pulses once per byte
//     busy, done, error : status; done pulses at the end, error is a sticky
//                         ack timeout cleared by reset or cmd_start
//     link_out          : [31]=ready, [30]=start, [7:0]=data, other bits 0
//     link_in           : [31]=ack (asynchronous), [7:0]=result
//     debug_state       : one-hot phase IDLE/TX/RX/END
// -----------------------------------------------------------------------------
module hps_link_initiator
   import hps_link_initiator_pkg::*;
#(
   parameter int unsigned N_TX           = 16,
   parameter int unsigned N_RX           = 8,
   parameter int unsigned START_HOLD     = 4,
   parameter int unsigned SETUP_CYCLES   = 2,
   parameter int unsigned SETTLE_CYCLES  = 8,
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cmd_start,
   input  logic [7:0]  tx_data,
   input  logic        tx_valid,
   output logic        tx_ready,
   output logic [7:0]  rx_data,
   output logic        rx_valid,
   output logic        busy,
   output logic        done,
   output logic        error,
   output logic [31:0] link_out,
   input  logic [31:0] link_in,
   output logic [3:0]  debug_state
);

   localparam int unsigned TXW = $clog2(N_TX + 1);
   localparam int unsigned RXW = $clog2(N_RX + 1);
   localparam int unsigned WW  = $clog2(TIMEOUT_CYCLES + 1);

   localparam logic [TXW-1:0] TX_LAST     = TXW'(N_TX - 1);
   localparam logic [RXW-1:0] RX_LAST     = RXW'(N_RX - 1);
   localparam logic [WW-1:0]  START_END   = WW'(START_HOLD - 1);
   localparam logic [WW-1:0]  SETUP_END   = WW'(SETUP_CYCLES - 1);
   localparam logic [WW-1:0]  SETTLE_END  = WW'(SETTLE_CYCLES - 1);
   localparam logic [WW-1:0]  TIMEOUT_END = WW'(TIMEOUT_CYCLES - 1);

   state_e         state_q, state_d;
   logic [WW-1:0]  wait_q, wait_d;
   logic [TXW-1:0] tx_cnt_q, tx_cnt_d;
   logic [RXW-1:0] rx_cnt_q, rx_cnt_d;
   logic           latched_q, latched_d;
   logic [7:0]     data_q, data_d;
   logic [7:0]     rx_data_q, rx_data_d;
   logic           rx_valid_q, rx_valid_d;
   logic           error_q, error_d;

   logic ack_s;
   logic wait_expired;
   logic unused_link_in;

   // Only ack is asynchronous; result bits are read after the settle window.
   link_sync u_ack_sync (
      .clk_i    (clk),
      .reset_ni (reset),
      .d_i      (link_in[LINK_ACK_BIT]),
      .q_o      (ack_s)
   );

   assign unused_link_in = ^link_in[LINK_ACK_BIT-1:LINK_DATA_MSB+1];
   assign wait_expired   = (wait_q == TIMEOUT_END);

   // ---------------------------------------------------------------- state reg
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q    <= ST_IDLE;
         wait_q     <= '0;
         tx_cnt_q   <= '0;
         rx_cnt_q   <= '0;
         latched_q  <= 1'b0;
         data_q     <= '0;
         rx_data_q  <= '0;
         rx_valid_q <= 1'b0;
         error_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         wait_q     <= wait_d;
         tx_cnt_q   <= tx_cnt_d;
         rx_cnt_q   <= rx_cnt_d;
         latched_q  <= latched_d;
         data_q     <= data_d;
         rx_data_q  <= rx_data_d;
         rx_valid_q <= rx_valid_d;
         error_q    <= error_d;
      end
   end

   // --------------------------------------------------------------- next state
   // wait_q is a shared cycle counter: it restarts at every state change, so it
   // times START hold, data setup, settle and each ack-wait independently.
   always_comb begin
      state_d    = state_q;
      wait_d     = wait_q + 1'b1;
      tx_cnt_d   = tx_cnt_q;
      rx_cnt_d   = rx_cnt_q;
      latched_d  = latched_q;
      data_d     = data_q;
      error_d    = error_q;
      rx_valid_d = (state_q == ST_RX_SAMPLE);
      rx_data_d  = (state_q == ST_RX_SAMPLE) ? link_in[LINK_DATA_MSB:LINK_DATA_LSB]
                                             : rx_data_q;

      unique case (state_q)
         ST_IDLE, ST_ERROR: begin
            wait_d = '0;
            if (cmd_start) begin
               error_d  = 1'b0;
               tx_cnt_d = '0;
               rx_cnt_d = '0;
               state_d  = ST_START;
            end
         end

         ST_START: begin
            if (wait_q == START_END) begin
               state_d   = ST_TX_SETUP;
               wait_d    = '0;
               latched_d = 1'b0;
            end
         end

         // Two sub-phases: waiting for a byte (no timeout), then holding it
         // stable on the link before ready is raised.
         ST_TX_SETUP: begin
            if (!latched_q) begin
               wait_d = '0;
               if (tx_valid) begin
                  data_d    = tx_data;
                  latched_d = 1'b1;
               end
            end else if (wait_q >= SETUP_END && !ack_s) begin
               state_d = ST_TX_REQ;
               wait_d  = '0;
            end
         end

         ST_TX_REQ: begin
            if (ack_s) begin
               state_d = ST_TX_REL;
               wait_d  = '0;
            end else if (wait_expired) begin
               state_d = ST_ERROR;
               error_d = 1'b1;
               wait_d  = '0;
            end
         end

         ST_TX_REL: begin
            if (!ack_s) begin
               tx_cnt_d = tx_cnt_q + 1'b1;
               wait_d   = '0;
               if (tx_cnt_q == TX_LAST) begin
                  state_d = ST_SETTLE;
               end else begin
                  state_d   = ST_TX_SETUP;
                  latched_d = 1'b0;
               end
            end else if (wait_expired) begin
               state_d = ST_ERROR;
               error_d = 1'b1;
               wait_d  = '0;
            end
         end

         ST_SETTLE: begin
            if (wait_q == SETTLE_END) begin
               state_d = ST_RX_SAMPLE;
               wait_d  = '0;
            end
         end

         ST_RX_SAMPLE: begin
            state_d = ST_RX_REQ;
            wait_d  = '0;
         end

         ST_RX_REQ: begin
            if (ack_s) begin
               state_d = ST_RX_REL;
               wait_d  = '0;
            end else if (wait_expired) begin
               state_d = ST_ERROR;
               error_d = 1'b1;
               wait_d  = '0;
            end
         end

         ST_RX_REL: begin
            if (!ack_s) begin
               rx_cnt_d = rx_cnt_q + 1'b1;
               wait_d   = '0;
               state_d  = (rx_cnt_q == RX_LAST) ? ST_DONE : ST_SETTLE;
            end else if (wait_expired) begin
               state_d = ST_ERROR;
               error_d = 1'b1;
               wait_d  = '0;
            end
         end

         ST_DONE: begin
            state_d = ST_IDLE;
            wait_d  = '0;
         end

         default: begin
            state_d = ST_IDLE;
            wait_d  = '0;
         end
      endcase
   end

   // ------------------------------------------------------------------ outputs
   always_comb begin
      link_out = '0;
      tx_ready = 1'b0;
      busy     = 1'b0;
      done     = 1'b0;

      unique case (state_q)
         ST_START: begin
            busy                     = 1'b1;
            link_out[LINK_START_BIT] = 1'b1;
         end
         ST_TX_SETUP: begin
            busy     = 1'b1;
            tx_ready = !latched_q;
            if (latched_q) begin
               link_out[LINK_DATA_MSB:LINK_DATA_LSB] = data_q;
            end
         end
         ST_TX_REQ: begin
            busy                                  = 1'b1;
            link_out[LINK_READY_BIT]              = 1'b1;
            link_out[LINK_DATA_MSB:LINK_DATA_LSB] = data_q;
         end
         ST_TX_REL: begin
            busy                                  = 1'b1;
            link_out[LINK_DATA_MSB:LINK_DATA_LSB] = data_q;
         end
         ST_SETTLE, ST_RX_SAMPLE, ST_RX_REL: begin
            busy = 1'b1;
         end
         ST_RX_REQ: begin
            busy                     = 1'b1;
            link_out[LINK_READY_BIT] = 1'b1;
         end
         ST_DONE: begin
            done = 1'b1;
         end
         default: begin
         end
      endcase
   end

   assign rx_data     = rx_data_q;
   assign rx_valid    = rx_valid_q;
   assign error       = error_q;
   assign debug_state = debug_code(state_q);

endmodule

// File: tb/tb_hps_link_initiator.sv
// -----------------------------------------------------------------------------
// tb_hps_link_initiator
//   Drives hps_link_initiator against a behavioural responder (partner with a
//   3-flop ready path; its result byte k is operand[k] + operand[k+8] mod 256)
//   and checks results against a queue model built from the accepted bytes.
// -----------------------------------------------------------------------------
module tb_hps_link_initiator;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        cmd_start = 1'b0;
   logic [7:0]  tx_data = '0;
   logic        tx_valid = 1'b0;
   logic        tx_ready;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        busy;
   logic        done;
   logic        error;
   logic [31:0] link_out;
   logic [31:0] link_in;
   logic [3:0]  debug_state;

   always #5 clk = ~clk;

   hps_link_initiator dut (
      .clk         (clk),
      .reset       (reset),
      .cmd_start   (cmd_start),
      .tx_data     (tx_data),
      .tx_valid    (tx_valid),
      .tx_ready    (tx_ready),
      .rx_data     (rx_data),
      .rx_valid    (rx_valid),
      .busy        (busy),
      .done        (done),
      .error       (error),
      .link_out    (link_out),
      .link_in     (link_in),
      .debug_state (debug_state)
   );

   // ---------------------------------------------------------------- responder
   logic        r1, r2, ack_q;
   logic        ack_kill = 1'b0;
   logic [22:0] junk;
   logic [7:0]  rb [16];
   logic [7:0]  rsp_res;
   int unsigned rsp_tx, rsp_rx;
   int unsigned cyc_cnt = 0;

   always @(posedge clk) begin
      cyc_cnt <= cyc_cnt + 1;
      junk    <= 23'($urandom);
      if (!reset) begin
         r1 <= 1'b0; r2 <= 1'b0; ack_q <= 1'b0;
         rsp_tx <= 0; rsp_rx <= 0;
      end else begin
         r1    <= link_out[31];
         r2    <= r1;
         ack_q <= r2;
         if (link_out[30]) begin
            rsp_tx <= 0;
            rsp_rx <= 0;
         end else if (r2 && !ack_q) begin
            if (rsp_tx < 16) begin
               rb[rsp_tx[3:0]] <= link_out[7:0];
               rsp_tx <= rsp_tx + 1;
            end else begin
               rsp_rx <= rsp_rx + 1;
            end
         end
      end
   end

   always_comb begin
      rsp_res = rb[rsp_rx % 8] + rb[(rsp_rx % 8) + 8];
      link_in = {ack_q & ~ack_kill, junk, rsp_res};
   end

   // ------------------------------------------------------------- scoreboard
   int checks = 0;
   int failures = 0;
   logic [7:0] acc_q [$];
   logic [7:0] exp_q [$];
   logic [7:0] got_q [$];
   int rx_pulses = 0;
   int done_pulses = 0;
   int ready_rises_tx = 0;
   logic prev_ready = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc_cnt);
      end
   endtask

   always @(negedge clk) begin
      if (reset) begin
         chk("link_out_reserved_zero", link_out & 32'h3FFF_FF00, 32'h0);
         chk("debug_onehot", 32'($onehot(debug_state)), 32'h1);
         chk("busy_vs_phase", busy, (debug_state == 4'b0010 || debug_state == 4'b0100));
         if (tx_valid && tx_ready) begin
            acc_q.push_back(tx_data);
            if (acc_q.size() == 16)
               for (int k = 0; k < 8; k++) exp_q.push_back(8'(acc_q[k] + acc_q[k+8]));
         end
         if (link_out[31] && !prev_ready && debug_state == 4'b0010) begin
            ready_rises_tx++;
            chk("ready_after_latch", acc_q.size() >= ready_rises_tx, 1'b1);
            if (acc_q.size() >= ready_rises_tx)
               chk("ready_data", link_out[7:0], acc_q[ready_rises_tx-1]);
         end
         if (rx_valid) begin
            rx_pulses++;
            got_q.push_back(rx_data);
            if (exp_q.size() == 0) chk("rx_unexpected", 1'b1, 1'b0);
            else chk("rx_data", rx_data, exp_q.pop_front());
         end
         if (done) done_pulses++;
      end
      prev_ready = link_out[31];
   end

   // ------------------------------------------------------------------ tasks
   // All tasks are entered and left 1 time unit after a rising edge.
   task automatic feed_byte(input logic [7:0] b, input int gap);
      int stall = 0;
      repeat (gap) begin @(posedge clk); #1; end
      tx_data  = b;
      tx_valid = 1'b1;
      while (!tx_ready && !error && stall < 3000) begin @(posedge clk); #1; stall++; end
      chk("tx_accept", tx_ready, 1'b1);
      @(posedge clk); #1;
      tx_valid = 1'b0;
   endtask

   task automatic start_txn();
      acc_q.delete(); exp_q.delete(); got_q.delete();
      rx_pulses = 0; done_pulses = 0; ready_rises_tx = 0;
      cmd_start = 1'b1;
      @(posedge clk); #1;
      cmd_start = 1'b0;
      chk("error_cleared_by_start", error, 1'b0);
      chk("busy_after_start", busy, 1'b1);
   endtask

   task automatic run_txn(input logic [7:0] b [16], input int gap, input bit pulse_busy);
      start_txn();
      fork
         begin
            for (int i = 0; i < 16; i++) begin
               if (pulse_busy && i == 5) begin
                  cmd_start = 1'b1; @(posedge clk); #1; cmd_start = 1'b0;
               end
               if (!error) feed_byte(b[i], gap);
            end
         end
         begin
            int unsigned n = 0;
            while (!done && !error && n < 8000) begin @(posedge clk); #1; n++; end
         end
      join
      chk("txn_done", done, 1'b1);
      chk("busy_at_done", busy, 1'b0);
      chk("error_at_done", error, 1'b0);
      @(posedge clk); #1;
      chk("done_one_cycle", done, 1'b0);
      chk("debug_idle_after", debug_state, 4'b0001);
      repeat (2) begin @(posedge clk); #1; end
      chk("rx_pulse_count", rx_pulses, 8);
      chk("done_pulse_count", done_pulses, 1);
      chk("ready_edges_per_byte", ready_rises_tx, 16);
      chk("results_outstanding", exp_q.size(), 0);
   endtask

   // --------------------------------------------------------------- stimulus
   logic [7:0] bytes [16];
   logic [7:0] lit1 [8] = '{8'd10, 8'd12, 8'd14, 8'd16, 8'd18, 8'd20, 8'd22, 8'd24};

   initial begin
      int unsigned t0;
      int unsigned n;

      reset = 1'b0;
      repeat (3) begin @(posedge clk); #1; end
      chk("rst_link_out", link_out, 32'h0);
      chk("rst_tx_ready", tx_ready, 1'b0);
      chk("rst_rx_valid", rx_valid, 1'b0);
      chk("rst_rx_data", rx_data, 8'h0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_error", error, 1'b0);
      chk("rst_debug", debug_state, 4'b0001);
      reset = 1'b1;
      @(posedge clk); #1;

      // Bytes 1..16 -> 10,12,...,24
      for (int i = 0; i < 16; i++) bytes[i] = 8'(i + 1);
      run_txn(bytes, 0, 1'b0);
      for (int k = 0; k < 8; k++)
         if (got_q.size() > k) chk("t1_literal", got_q[k], lit1[k]);

      // 8-bit wrap on the first result
      for (int i = 0; i < 16; i++) bytes[i] = 8'($urandom);
      bytes[0] = 8'hFF; bytes[8] = 8'h02;
      run_txn(bytes, 0, 1'b0);
      if (got_q.size() > 0) chk("t2_wrap", got_q[0], 8'h01);

      // Slow producer: one byte every 50 cycles
      for (int i = 0; i < 16; i++) bytes[i] = 8'(i + 1);
      run_txn(bytes, 50, 1'b0);
      for (int k = 0; k < 8; k++)
         if (got_q.size() > k) chk("t3_literal", got_q[k], lit1[k]);

      // cmd_start while busy is ignored
      for (int i = 0; i < 16; i++) bytes[i] = 8'($urandom);
      run_txn(bytes, 1, 1'b1);

      // Random transactions
      for (int t = 0; t < 5; t++) begin
         for (int i = 0; i < 16; i++) bytes[i] = 8'($urandom);
         run_txn(bytes, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      end

      // Ack stuck low -> timeout
      ack_kill = 1'b1;
      t0 = cyc_cnt;
      start_txn();
      feed_byte(8'h5A, 0);
      n = 0;
      while (!error && n < 1500) begin @(posedge clk); #1; n++; end
      chk("timeout_error", error, 1'b1);
      chk("timeout_window", (cyc_cnt - t0 >= 1024) && (cyc_cnt - t0 <= 1045), 1'b1);
      chk("timeout_link_out", link_out, 32'h0);
      chk("timeout_busy", busy, 1'b0);
      chk("timeout_debug", debug_state, 4'b1000);
      repeat (20) begin @(posedge clk); #1; end
      chk("error_sticky", error, 1'b1);
      ack_kill = 1'b0;
      for (int i = 0; i < 16; i++) bytes[i] = 8'($urandom);
      run_txn(bytes, 0, 1'b0);

      // Reset at TX byte 7, then a fresh transaction
      start_txn();
      for (int i = 0; i < 7; i++) feed_byte(8'($urandom), 0);
      chk("bytes_before_reset", acc_q.size(), 7);
      reset = 1'b0;
      @(posedge clk); #1;
      chk("midrst_link_out", link_out, 32'h0);
      chk("midrst_busy", busy, 1'b0);
      chk("midrst_tx_ready", tx_ready, 1'b0);
      chk("midrst_rx_valid", rx_valid, 1'b0);
      chk("midrst_done", done, 1'b0);
      chk("midrst_error", error, 1'b0);
      chk("midrst_debug", debug_state, 4'b0001);
      repeat (2) begin @(posedge clk); #1; end
      reset = 1'b1;
      @(posedge clk); #1;
      for (int i = 0; i < 16; i++) bytes[i] = 8'($urandom);
      run_txn(bytes, 0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
      $fatal(1);
   end

endmodule
